// File: rtl/pool_sequencer.sv
// pool_sequencer: 2x2 max-pool sequencer over CHANNELS feature maps of IN_X x IN_Y samples.
// Each output reads four window samples from a ReLU buffer and keeps the unsigned maximum.
// The pooled value is then written to a sink with a ready handshake.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start, abort     begin a run (sampled only when idle); terminate a run
//   busy, done       high while not idle; one-cycle completion pulse
//   rd_en, rd_addr   ReLU buffer read strobe/address (data returns one cycle later)
//   rd_data          read data
//   wr_en, wr_addr   pooled-result write request/address
//   wr_data          pooled 2x2 maximum
//   wr_ready         sink accepts the write when wr_en && wr_ready
module pool_sequencer #(
  parameter int unsigned DATA_WIDTH = 45,
  parameter int unsigned IN_X       = 24,
  parameter int unsigned IN_Y       = 24,
  parameter int unsigned CHANNELS   = 8,
  localparam int unsigned OUT_X     = IN_X / 2,
  localparam int unsigned OUT_Y     = IN_Y / 2,
  localparam int unsigned RA_W      = $clog2(CHANNELS * IN_X * IN_Y),
  localparam int unsigned WA_W      = $clog2(CHANNELS * OUT_X * OUT_Y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [RA_W-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [WA_W-1:0]       wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned OX_W = (OUT_X > 1) ? $clog2(OUT_X) : 1;
  localparam int unsigned OY_W = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StLast, StWrite, StFinish} state_t;

  state_t                state_q;
  logic [CH_W-1:0]       ch_q, ch_nxt;
  logic [OX_W-1:0]       ox_q, ox_nxt;
  logic [OY_W-1:0]       oy_q, oy_nxt;
  logic [1:0]            k_q;
  logic [DATA_WIDTH-1:0] max_q;
  // cap_q: rd_data this cycle belongs to the current window; first_q: it is sample 0.
  logic                  cap_q;
  logic                  first_q;
  logic                  oy_last, ox_last, ch_last, last_out;

  // Window sample k: bit 1 selects the odd row, bit 0 the odd column.
  function automatic logic [RA_W-1:0] rd_addr_of(input logic [CH_W-1:0] c,
                                                 input logic [OX_W-1:0] x,
                                                 input logic [OY_W-1:0] y,
                                                 input logic [1:0]      kk);
    int unsigned a;
    a = 32'(c) * IN_X * IN_Y + (2 * 32'(x) + 32'(kk[1])) * IN_Y + 2 * 32'(y) + 32'(kk[0]);
    return RA_W'(a);
  endfunction

  assign oy_last  = (oy_q == OY_W'(OUT_Y - 1));
  assign ox_last  = (ox_q == OX_W'(OUT_X - 1));
  assign ch_last  = (ch_q == CH_W'(CHANNELS - 1));
  assign last_out = oy_last && ox_last && ch_last;
  assign wr_data  = max_q;

  always_comb begin
    oy_nxt = oy_q + OY_W'(1);
    ox_nxt = ox_q;
    ch_nxt = ch_q;
    if (oy_last) begin
      oy_nxt = '0;
      ox_nxt = ox_q + OX_W'(1);
      if (ox_last) begin
        ox_nxt = '0;
        ch_nxt = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (abort && state_q != StIdle)) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      max_q   <= '0;
      ch_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      k_q     <= '0;
      cap_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap_q && (first_q || rd_data > max_q)) begin
        max_q <= rd_data;
      end
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            ch_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            k_q     <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          cap_q   <= 1'b1;
          first_q <= (k_q == 2'd0);
          if (k_q == 2'd3) begin
            rd_en   <= 1'b0;
            state_q <= StLast;
          end else begin
            k_q     <= k_q + 2'd1;
            rd_addr <= rd_addr_of(ch_q, ox_q, oy_q, k_q + 2'd1);
          end
        end
        StLast: begin
          // The fourth sample is captured at the end of this cycle.
          cap_q   <= 1'b0;
          wr_en   <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_out) begin
              done    <= 1'b1;
              state_q <= StFinish;
            end else begin
              ch_q    <= ch_nxt;
              ox_q    <= ox_nxt;
              oy_q    <= oy_nxt;
              k_q     <= '0;
              wr_addr <= wr_addr + WA_W'(1);
              rd_addr <= rd_addr_of(ch_nxt, ox_nxt, oy_nxt, 2'd0);
              rd_en   <= 1'b1;
              state_q <= StRead;
            end
          end
        end
        StFinish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          rd_en   <= 1'b0;
          wr_en   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_sequencer.sv
// tb_pool_sequencer: randomized self-checking bench for pool_sequencer at default parameters.
// A behavioural memory feeds the DUT; expected pooled values are the max of each 2x2 window.
module tb_pool_sequencer;

  localparam int DW      = 45;
  localparam int IX      = 24;
  localparam int IY      = 24;
  localparam int CH      = 8;
  localparam int OX      = IX / 2;
  localparam int OY      = IY / 2;
  localparam int N_OUT   = CH * OX * OY;
  localparam int RUN_CYC = 6 * N_OUT;
  localparam int MEM_N   = CH * IX * IY;

  logic          clk = 1'b0;
  logic          rst, start, abort, wr_ready;
  logic          busy, done, rd_en, wr_en;
  logic [12:0]   rd_addr;
  logic [10:0]   wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [MEM_N];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_n = 0;
  int done_cnt = 0;
  int stall_cyc = 0;
  int stall_cnt = 0;
  int overlap_cnt = 0;
  int bp_mode = 0;
  int cyc;
  bit found;
  logic [DW-1:0] first_data, last_data;
  logic [DW-1:0] all_ones;

  always #5 clk = ~clk;

  pool_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready)
  );

  // ReLU buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pooled value of output n: max of its 2x2 window in memory.
  function automatic logic [DW-1:0] model(input int n);
    int c, r, x, y, a;
    logic [DW-1:0] m;
    c = n / (OX * OY);
    r = n % (OX * OY);
    x = r / OY;
    y = r % OY;
    a = c * IX * IY + 2 * x * IY + 2 * y;
    m = mem[a];
    if (mem[a + 1] > m) m = mem[a + 1];
    if (mem[a + IY] > m) m = mem[a + IY];
    if (mem[a + IY + 1] > m) m = mem[a + IY + 1];
    return m;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rd_en && wr_en) overlap_cnt++;
    if (done) done_cnt++;
    if (wr_en && !wr_ready) begin
      stall_cyc++;
      if (bp_mode == 2) begin
        check("stall_wr_addr", wr_addr, 2);
        check("stall_wr_data", wr_data, model(2));
        check("stall_rd_en", rd_en, 0);
      end
    end
    if (wr_en && wr_ready && !rst && !abort) begin
      check("wr_addr", wr_addr, exp_n);
      check("wr_data", wr_data, model(exp_n));
      if (exp_n == 0) first_data = wr_data;
      last_data = wr_data;
      exp_n++;
    end
  end

  // Write backpressure driver.
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: wr_ready = ($urandom_range(3) != 0);
        2: begin
          if (wr_en && wr_addr == 11'd2 && stall_cnt < 10) begin
            wr_ready = 1'b0;
            stall_cnt++;
          end else begin
            wr_ready = 1'b1;
          end
        end
        default: wr_ready = 1'b1;
      endcase
    end
  end

  task automatic prep();
    exp_n     = 0;
    done_cnt  = 0;
    stall_cyc = 0;
    stall_cnt = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_N; i++) mem[i] = DW'({$urandom, $urandom});
  endtask

  // Pulse start, then count cycles until done is seen (bounded).
  task automatic do_run(input int budget, input int repulse_at, output int cycles);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == repulse_at);
      if (done) break;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    all_ones = '1;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < MEM_N; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Ramp memory, no backpressure.
    prep();
    do_run(RUN_CYC + 100, 0, cyc);
    settle();
    check("ramp_cycles", cyc, RUN_CYC);
    check("ramp_writes", exp_n, N_OUT);
    check("ramp_last", last_data, MEM_N - 1);
    check("ramp_done_cnt", done_cnt, 1);
    check("ramp_idle_busy", busy, 0);

    // Random data, directed first window, random backpressure.
    fill_random();
    mem[0]  = DW'(5);
    mem[1]  = all_ones;
    mem[24] = '0;
    mem[25] = DW'(7);
    bp_mode = 1;
    prep();
    do_run(RUN_CYC * 2, 0, cyc);
    settle();
    bp_mode = 0;
    check("win_first_data", first_data, all_ones);
    check("bp_cycles", cyc, RUN_CYC + stall_cyc);
    check("bp_writes", exp_n, N_OUT);
    check("bp_done_cnt", done_cnt, 1);

    // Ten-cycle stall on write index 2.
    fill_random();
    bp_mode = 2;
    prep();
    do_run(RUN_CYC + 200, 0, cyc);
    settle();
    bp_mode = 0;
    check("stall_cycles", stall_cyc, 10);
    check("stall_run_cycles", cyc, RUN_CYC + 10);
    check("stall_writes", exp_n, N_OUT);

    // Abort during the write of output 100.
    fill_random();
    prep();
    found = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (wr_en && wr_addr == 11'd100) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_found_write", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start_busy", busy, 0);
    @(posedge clk);
    #1;
    check("idle_abort_start_rd_en", rd_en, 0);
    prep();
    do_run(RUN_CYC + 100, 0, cyc);
    settle();
    check("rerun_cycles", cyc, RUN_CYC);
    check("rerun_writes", exp_n, N_OUT);
    check("rerun_done_cnt", done_cnt, 1);

    // Reset mid-run.
    fill_random();
    prep();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    prep();
    do_run(RUN_CYC + 100, 0, cyc);
    settle();
    check("postrst_cycles", cyc, RUN_CYC);
    check("postrst_writes", exp_n, N_OUT);
    check("postrst_done_cnt", done_cnt, 1);

    // Start pulsed again while busy.
    fill_random();
    prep();
    do_run(RUN_CYC + 100, 50, cyc);
    repeat (20) @(posedge clk);
    #1;
    check("repulse_cycles", cyc, RUN_CYC);
    check("repulse_writes", exp_n, N_OUT);
    check("repulse_done_cnt", done_cnt, 1);
    check("repulse_idle", busy, 0);

    check("rd_wr_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
